cva6v_vfabric_req_sequencer: RTL

- Per-lane controller that sequences one strided vector memory command into element requests on a single fixed-latency vector fabric input port.
- Issues reads and writes, tracks in-flight reads with credits and buffers read data in a FIFO. Read data can be back-pressured even though the fabric response cannot be stalled.
- Sits between the vector load/store unit and one fabric request/response port.

---
 rtl/cva6v_vfabric_seq_pkg.sv | 30 +++
 rtl/cva6v_vfabric_rsp_fifo.sv | 58 +++++
 rtl/cva6v_vfabric_req_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cva6v_vfabric_seq_pkg.sv
// Shared types and default sizing for the vector fabric request sequencer.
package cva6v_vfabric_seq_pkg;

    localparam int unsigned DefAddrWidth = 32;
    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefCntWidth  = 16;
    localparam int unsigned DefRspDepth  = 4;

    localparam int unsigned StrbWidth   = DefDataWidth / 8;
    localparam int unsigned CreditWidth = $clog2(DefRspDepth + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_e;

    typedef struct packed {
        logic [DefAddrWidth-1:0] base;
        logic [DefAddrWidth-1:0] stride;
        logic [DefCntWidth-1:0]  count;
        logic                    write;
    } cmd_t;

    // Counter width able to hold 0..depth inclusive.
    function automatic int unsigned credit_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/cva6v_vfabric_rsp_fifo.sv
// Synchronous read-data FIFO with occupancy count; async active-high reset.
module cva6v_vfabric_rsp_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4,
    parameter int unsigned CntW  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] pop_data,
    output logic [CntW-1:0]  count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full     = (count == CntW'(Depth));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cva6v_vfabric_req_sequencer.sv
// Sequences one strided vector command into element requests on a fixed-latency
// fabric port; read data is buffered so the consumer may stall without losing responses.
module cva6v_vfabric_req_sequencer
    import cva6v_vfabric_seq_pkg::*;
#(
    parameter int unsigned AddrWidth             = DefAddrWidth,
    parameter int unsigned DataWidth             = DefDataWidth,
    parameter int unsigned CntWidth              = DefCntWidth,
    parameter int unsigned RspDepth              = DefRspDepth,
    parameter int unsigned MemoryResponseLatency = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [AddrWidth-1:0]   cmd_base_i,
    input  logic [AddrWidth-1:0]   cmd_stride_i,
    input  logic [CntWidth-1:0]    cmd_count_i,
    input  logic                   cmd_write_i,
    input  logic                   wdata_valid_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] wstrb_i,
    output logic                   wdata_ready_o,
    output logic                   req_q_valid_o,
    input  logic                   req_q_ready_i,
    output logic [AddrWidth-1:0]   req_addr_o,
    output logic                   req_write_o,
    output logic [DataWidth-1:0]   req_data_o,
    output logic [DataWidth/8-1:0] req_strb_o,
    input  logic                   rsp_p_valid_i,
    input  logic [DataWidth-1:0]   rsp_data_i,
    output logic                   rdata_valid_o,
    output logic [DataWidth-1:0]   rdata_o,
    input  logic                   rdata_ready_i,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int unsigned CredW = credit_width(RspDepth);

    state_e                           state_q, state_d;
    cmd_t                             cmd_q;
    logic [AddrWidth-1:0]             cur_addr_q;
    logic [CntWidth-1:0]              remaining_q;
    logic [CredW-1:0]                 inflight_q;
    logic [CredW-1:0]                 fifo_count;
    logic [CredW:0]                   credit_sum;
    logic [MemoryResponseLatency-1:0] lat_q;
    logic done_q, done_d;
    logic cmd_hs, req_hs, read_hs, credit_ok;
    logic fifo_pop, fifo_empty, fifo_full;

    // Credits come from registered counts only, keeping rdata_ready_i off the request path.
    assign credit_sum = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign credit_ok  = credit_sum < (CredW + 1)'(RspDepth);
    assign cmd_hs     = cmd_valid_i & cmd_ready_o;
    assign req_hs     = req_q_valid_o & req_q_ready_i;
    assign read_hs    = req_hs & ~cmd_q.write;
    assign fifo_pop   = rdata_valid_o & rdata_ready_i;

    assign rdata_valid_o = ~fifo_empty;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        done_d        = 1'b0;
        cmd_ready_o   = 1'b0;
        req_q_valid_o = 1'b0;
        req_addr_o    = '0;
        req_write_o   = 1'b0;
        req_data_o    = '0;
        req_strb_o    = '0;
        wdata_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    if (cmd_count_i == '0) done_d  = 1'b1;
                    else                   state_d = ISSUE;
                end
            end
            ISSUE: begin
                req_addr_o  = cur_addr_q;
                req_write_o = cmd_q.write;
                if (cmd_q.write) begin
                    req_q_valid_o = wdata_valid_i;
                    req_data_o    = wdata_i;
                    req_strb_o    = wstrb_i;
                    wdata_ready_o = wdata_valid_i & req_q_ready_i;
                end else begin
                    req_q_valid_o = credit_ok;
                end
                if (req_q_valid_o && req_q_ready_i && remaining_q == CntWidth'(1)) begin
                    if (cmd_q.write) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Exit on the cycle the last element leaves so done_o follows the final pop directly.
                if (inflight_q == '0 &&
                    (fifo_empty || (fifo_count == CredW'(1) && fifo_pop))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_q       <= '0;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            inflight_q  <= '0;
            lat_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= done_d;
            lat_q  <= (lat_q << 1) | MemoryResponseLatency'(read_hs);
            if (cmd_hs) begin
                cmd_q       <= '{base: cmd_base_i, stride: cmd_stride_i,
                                 count: cmd_count_i, write: cmd_write_i};
                cur_addr_q  <= cmd_base_i;
                remaining_q <= cmd_count_i;
            end else if (req_hs) begin
                cur_addr_q  <= cur_addr_q + cmd_q.stride;
                remaining_q <= remaining_q - CntWidth'(1);
            end
            case ({read_hs, rsp_p_valid_i})
                2'b10:   inflight_q <= inflight_q + CredW'(1);
                2'b01:   inflight_q <= inflight_q - CredW'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    cva6v_vfabric_rsp_fifo #(
        .Width (DataWidth),
        .Depth (RspDepth),
        .CntW  (CredW)
    ) u_rsp_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (rsp_p_valid_i),
        .push_data (rsp_data_i),
        .pop       (fifo_pop),
        .pop_data  (rdata_o),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    a_rsp_has_credit: assert property (@(posedge clk_i) disable iff (rst_i)
        rsp_p_valid_i |-> inflight_q != '0);
    a_rsp_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        rsp_p_valid_i |-> !fifo_full);
    a_rsp_latency: assert property (@(posedge clk_i) disable iff (rst_i)
        rsp_p_valid_i |-> lat_q[MemoryResponseLatency-1]);
    a_first_addr: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == ISSUE && remaining_q == cmd_q.count) |-> cur_addr_q == cmd_q.base);

endmodule
